// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences S/R/E for a gated SR latch from one-cycle
// set/clear requests. Each transaction is SETUP (S/R stable, E low),
// PULSE (E high), HOLD (S/R stable, E low), DONE (everything low, done
// pulse) and then back to IDLE.
//
// Build option: define SR_DRV_VERIFY_EN to compare the fed-back latch Q
// against the requested value on the last HOLD cycle. A mismatch is
// flagged on err together with done. Without it, q_in is ignored and
// err stays 0.
module sr_latch_driver #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_in,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic E,
    output logic done,
    output logic ill_req,
    output logic err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Terminal count for each timed phase. The counter restarts at 0 on
    // every state change, so a phase ends when it reaches PARAM-1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             e_q, e_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;
    logic             err_q, err_d;
    logic             q_mismatch;

`ifdef SR_DRV_VERIFY_EN
    // Latch did not end up where this transaction drove it.
    assign q_mismatch = q_in ^ dir_q;
`else
    // Readback disabled: q_in is intentionally left unused.
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign q_mismatch  = 1'b0;
`endif

    // Next-state and registered-output logic for the phase sequencer.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        s_d     = s_q;
        r_d     = r_q;
        e_d     = e_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    // Contradictory request: flag it and never start.
                    ill_d = 1'b1;
                end else if (set_req) begin
                    state_d = ST_SETUP;
                    dir_d   = 1'b1;
                    s_d     = 1'b1;
                    r_d     = 1'b0;
                    e_d     = 1'b0;
                end else if (clr_req) begin
                    state_d = ST_SETUP;
                    dir_d   = 1'b0;
                    s_d     = 1'b0;
                    r_d     = 1'b1;
                    e_d     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_PULSE;
                    e_d     = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_HOLD;
                    e_d     = 1'b0;
                end
            end
            ST_HOLD: begin
                // S/R drop only here, when E has already been low for HOLD.
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_DONE;
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    done_d  = 1'b1;
                    err_d   = q_mismatch;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
                e_d     = 1'b0;
            end
        endcase

        // Counter only runs inside timed phases and restarts on any change.
        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset clears outputs without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            s_q     <= s_d;
            r_q     <= r_d;
            e_q     <= e_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign S         = s_q;
    assign R         = r_q;
    assign E         = e_q;
    assign done      = done_q;
    assign ill_req   = ill_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: randomized and directed stimulus for sr_latch_driver,
// checked every cycle against a transaction-level timing model (elapsed
// cycles since accept) plus a behavioural gated SR latch on q_in.
module tb_sr_latch_driver;

    localparam int SC  = 1;
    localparam int PC  = 2;
    localparam int HC  = 1;
    localparam int CW  = 4;
    localparam int TOT = SC + PC + HC + 1;

    logic clk = 1'b0;
    logic rst;
    logic set_req;
    logic clr_req;
    logic q_in;
    logic req_ready, S, R, E, done, ill_req, err;

    always #5 clk = ~clk;

    sr_latch_driver #(
        .SETUP_CYC(SC),
        .PULSE_CYC(PC),
        .HOLD_CYC (HC),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .q_in     (q_in),
        .req_ready(req_ready),
        .S        (S),
        .R        (R),
        .E        (E),
        .done     (done),
        .ill_req  (ill_req),
        .err      (err)
    );

    // Behavioural gated SR latch driven by the DUT.
    logic q_lat    = 1'b0;
    logic force_q0 = 1'b0;
    always @(S or R or E) begin
        if (E) begin
            if (S) q_lat = 1'b1;
            else if (R) q_lat = 1'b0;
        end
    end
    assign q_in = force_q0 ? 1'b0 : q_lat;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_ill  = 0;

    // Reference model: position within the current transaction.
    bit m_busy;
    int m_t;
    bit m_dir;
    bit m_ill;
    bit m_mism;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_t    = 0;
        m_ill  = 1'b0;
        m_mism = 1'b0;
    endtask

    task automatic compare_all();
        bit drive, s_e, r_e, e_e, d_e, err_e;
        drive = m_busy && (m_t <= SC + PC + HC);
        s_e   = drive && m_dir;
        r_e   = drive && !m_dir;
        e_e   = m_busy && (m_t > SC) && (m_t <= SC + PC);
        d_e   = m_busy && (m_t == TOT);
`ifdef SR_DRV_VERIFY_EN
        err_e = d_e && m_mism;
`else
        err_e = 1'b0;
`endif
        chk("req_ready", int'(req_ready), int'(!m_busy));
        chk("S", int'(S), int'(s_e));
        chk("R", int'(R), int'(r_e));
        chk("E", int'(E), int'(e_e));
        chk("done", int'(done), int'(d_e));
        chk("ill_req", int'(ill_req), int'(m_ill));
        chk("err", int'(err), int'(err_e));
        chk("s_and_r", int'(S & R), 0);
        if (done === 1'b1) begin
            n_done++;
            if (err === 1'b1) n_err++;
            $display("txn %0d done dir=%0d err=%0d t=%0t", n_done, m_dir, err, $time);
        end
        if (ill_req === 1'b1) begin
            n_ill++;
            $display("ill_req %0d t=%0t", n_ill, $time);
        end
    endtask

    // One clock: drive requests, advance model at the edge, check at negedge.
    task automatic cycle(input bit s, input bit c);
        bit qs;
        set_req = s;
        clr_req = c;
        qs = force_q0 ? 1'b0 : q_lat;
        @(posedge clk);
        if (m_busy) begin
            if (m_t == SC + PC + HC) m_mism = (qs != m_dir);
            if (m_t == TOT) m_busy = 1'b0;
            else m_t++;
            m_ill = 1'b0;
        end else begin
            m_ill = s & c;
            if (s ^ c) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_dir  = s;
                m_mism = 1'b0;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int d0;
        int e0;
        int r;
        set_req = 1'b0;
        clr_req = 1'b0;
        rst     = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        @(negedge clk);
        compare_all();

        // Single set, then single clear; latch must follow.
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        chk("latch_after_set", int'(q_lat), 1);
        cycle(1'b0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0);
        chk("latch_after_clr", int'(q_lat), 0);

        // Both requests in IDLE: flag only, no transaction.
        d0 = n_done;
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        chk("ill_no_done", n_done - d0, 0);

        // set_req held for 10 cycles: two transactions.
        d0 = n_done;
        repeat (10) cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b0);
        chk("held_txns", n_done - d0, 2);

        // Asynchronous reset while E is high.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("pre_rst_E", int'(E), 1);
        d0 = n_done;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_S", int'(S), 0);
        chk("rst_async_R", int'(R), 0);
        chk("rst_async_E", int'(E), 0);
        chk("rst_async_ready", int'(req_ready), 1);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        repeat (4) cycle(1'b0, 1'b0);
        chk("rst_no_done", n_done - d0, 0);
        d0 = n_done;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        chk("post_rst_txn", n_done - d0, 1);

        // Readback: q_in forced low during a set, then the real latch.
        cycle(1'b0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0);
        e0 = n_err;
        force_q0 = 1'b1;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        force_q0 = 1'b0;
`ifdef SR_DRV_VERIFY_EN
        chk("forced_err_count", n_err - e0, 1);
`else
        chk("forced_err_count", n_err - e0, 0);
`endif
        e0 = n_err;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        chk("clean_err_count", n_err - e0, 0);

        // Random requests with occasional readback corruption.
        repeat (400) begin
            r = int'($urandom_range(0, 7));
            force_q0 = ($urandom_range(0, 9) == 0);
            cycle((r == 0) || (r == 2), (r == 1) || (r == 2));
        end
        force_q0 = 1'b0;
        repeat (8) cycle(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
